wb_trace_fifo: RTL and testbench
================================

// Module: wb_trace_fifo
// PURPOSE
//  Debug capture stage downstream of the processor/regfile write port. Snoops every regfile
//  write (enable, register index, data), timestamps it, and buffers it in a FIFO. A host or
//  UART/display block drains the FIFO through a valid/ready handshake.
//  Runs on the regfile clock, so it samples exactly the writes the regfile commits.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  ADDR_W  4   log2(DEPTH)
//  DATA_W  32  register data width
//  REG_W   5   register index width
//  TS_W    16  timestamp counter width
// PORTS
//  clock       in   1                    rising-edge clock; same net as regfile_clock
//  reset       in   1                    asynchronous, active-low; 0 clears all state
//  enable      in   1                    1 = capture writes; 0 = ignore the write port
//  clear       in   1                    synchronous flush of FIFO, drop count and overflow
//  wr_en       in   1                    regfile ctrl_writeEnable
//  wr_reg      in   REG_W                regfile ctrl_writeReg
//  wr_data     in   DATA_W               regfile data_writeReg
//  out_valid   out  1                    head entry present (FIFO not empty)
//  out_ready   in   1                    consumer accepts head when out_valid & out_ready
//  out_entry   out  TS_W+REG_W+DATA_W    {ts, reg, data} of head; all-zero when empty
//  count       out  ADDR_W+1             occupancy, 0..DEPTH
//  full        out  1                    count == DEPTH
//  overflow    out  1                    sticky: at least one event dropped
//  drop_count  out  16                   dropped events, saturates at 0xFFFF
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): pointers, count, timestamp, drop_count and overflow
//    go to 0. out_valid=0, out_entry=0, full=0. Takes effect mid-operation; buffered
//    entries are lost.
//  - Timestamp: TS_W-bit free-running counter, +1 every clock, wraps 0xFFFF->0x0000.
//    An event captured at edge N stores the counter value held before edge N.
//  - Event: enable & wr_en & (wr_reg != 0) at a rising edge. Writes to r0 are never
//    captured, dropped or counted.
//  - Push: an event is accepted when !full, or when full and a pop occurs on the same edge.
//    Otherwise it is dropped: overflow<=1 and drop_count<=drop_count+1 (saturating).
//  - Pop: out_valid & out_ready at an edge removes the head. out_ready while empty is ignored.
//  - Latency: an event accepted at edge N gives out_valid=1 after edge N, when the FIFO was
//    empty. The FIFO is show-ahead: out_entry is the registered-storage head, muxed
//    combinationally and forced to 0 when empty.
//  - Push and pop on the same edge: count is unchanged and both pointers advance. On an
//    empty FIFO only the push takes effect, because out_valid was 0.
//  - Pointers are ADDR_W bits and wrap DEPTH-1 -> 0. count is tracked separately,
//    width ADDR_W+1.
//  - clear=1 at an edge: count, pointers, overflow and drop_count go to 0. clear overrides
//    any push or pop on that edge, and the event on that edge is discarded without being
//    counted. The timestamp is not cleared.
//  - enable=0 discards events silently. FIFO drain continues normally.
//  - No state machine beyond the FIFO and counters. All outputs except out_entry are
//    registered or derived directly from count.
// TESTING
//  1 Reset with reset=0, then release; hold wr_en=1, wr_reg=3, wr_data=0xDEADBEEF for one
//    edge -> next cycle out_valid=1, count=1, out_entry={ts,5'd3,32'hDEADBEEF}.
//  2 wr_en=1, wr_reg=0, data 0x1234 -> count stays 0, overflow=0, drop_count=0.
//  3 Out_ready=0 with 18 events on regs 1..18 -> count=16, full=1, overflow=1,
//    drop_count=2. Then drain -> regs 1..16 in order with ascending timestamps.
//  4 FIFO full with push and pop on the same edge -> count stays 16, overflow unchanged,
//    the new entry appears last after the drain.
//  5 FIFO holding 5 entries, clear=1 together with a push -> count=0, out_valid=0,
//    overflow=0, drop_count=0.
//  6 FIFO holding 3 entries, assert reset=0 between clock edges -> outputs are zero
//    immediately (asynchronous). Also verify the timestamp wraps after 65536 cycles.

Source files
------------

// File: rtl/wb_trace_fifo_if.sv
// Regfile write-port snoop and drain-side handshake for the trace FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface wb_trace_fifo_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TS_W   = 16
);
  logic                           wr_en;
  logic [REG_W-1:0]               wr_reg;
  logic [DATA_W-1:0]              wr_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [TS_W+REG_W+DATA_W-1:0]   out_entry;

  modport master (
    output wr_en, wr_reg, wr_data, out_ready,
    input  out_valid, out_entry
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, out_ready,
    output out_valid, out_entry
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Timestamped capture FIFO for regfile writes, drained through a show-ahead
// valid/ready port. Drops are counted (saturating) and flagged sticky.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TS_W   = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_clear,
  wb_trace_fifo_if.slave    bus,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_overflow,
  output logic [15:0]       o_drop_count
);

  localparam int ENTRY_W = TS_W + REG_W + DATA_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic [TS_W-1:0]    r_ts;
  logic               r_overflow;
  logic [15:0]        r_drop_count;

  logic w_event, w_empty, w_full, w_pop, w_push, w_drop;

  assign w_event = i_enable & bus.wr_en & (bus.wr_reg != '0);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = ~w_empty & bus.out_ready;
  // A full FIFO still accepts an event when the head leaves on the same edge.
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & ~w_push;

  // Storage is data only; validity is carried entirely by r_count.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_clear)
      r_mem[r_wr_ptr] <= {r_ts, bus.wr_reg, bus.wr_data};
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ts         <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (i_clear) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        if (w_push && !w_pop)
          r_count <= r_count + (ADDR_W+1)'(1);
        else if (w_pop && !w_push)
          r_count <= r_count - (ADDR_W+1)'(1);
        if (w_drop) begin
          r_overflow   <= 1'b1;
          r_drop_count <= sat_inc(r_drop_count);
        end
      end
    end
  end

  assign bus.out_valid = ~w_empty;
  assign bus.out_entry = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: vector table plus hand-written corner sequences.
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, clear;
  logic [4:0]  count;
  logic        full, overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] tb_ts;
  logic [15:0] ts_last;
  logic [15:0] ts_rec [18];

  wb_trace_fifo_if #(.DATA_W(32), .REG_W(5), .TS_W(16)) bus ();

  wb_trace_fifo #(.DEPTH(16), .ADDR_W(4), .DATA_W(32), .REG_W(5), .TS_W(16)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_enable     (enable),
    .i_clear      (clear),
    .bus          (bus),
    .o_count      (count),
    .o_full       (full),
    .o_overflow   (overflow),
    .o_drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference free-running cycle count: value held before each edge is the capture stamp.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 16'd0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  typedef struct {
    logic        en, clr, we;
    logic [4:0]  rg;
    logic [31:0] dat;
    logic        rdy;
    logic        e_vld;
    logic [4:0]  e_cnt;
    logic        e_full, e_ovf;
    logic [15:0] e_drop;
    logic [4:0]  e_rg;
    logic [31:0] e_dat;
    logic        chk_ts;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic clr, input logic we,
                        input logic [4:0] rg, input logic [31:0] dat, input logic rdy);
    enable        = en;
    clear         = clr;
    bus.wr_en     = we;
    bus.wr_reg    = rg;
    bus.wr_data   = dat;
    bus.out_ready = rdy;
  endtask

  task automatic step(input logic en, input logic clr, input logic we,
                      input logic [4:0] rg, input logic [31:0] dat, input logic rdy);
    set_in(en, clr, we, rg, dat, rdy);
    ts_last = tb_ts;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_head(input string name, input logic [4:0] rg,
                            input logic [31:0] dat, input logic [15:0] ts);
    check({name, "_vld"}, 64'(bus.out_valid), 64'd1);
    check({name, "_reg"}, 64'(bus.out_entry[36:32]), 64'(rg));
    check({name, "_dat"}, 64'(bus.out_entry[31:0]), 64'(dat));
    check({name, "_ts"},  64'(bus.out_entry[52:37]), 64'(ts));
  endtask

  initial begin
    //            en   clr  we   rg     dat            rdy  vld  cnt   full ovf  drop   e_rg   e_dat          chk_ts
    vt[0] = '{1'b1,1'b0,1'b0,5'd0, 32'h0,         1'b0,1'b0,5'd0, 1'b0,1'b0,16'd0,5'd0, 32'h0,         1'b0};
    vt[1] = '{1'b1,1'b0,1'b1,5'd3, 32'hDEADBEEF,  1'b0,1'b1,5'd1, 1'b0,1'b0,16'd0,5'd3, 32'hDEADBEEF,  1'b1};
    vt[2] = '{1'b1,1'b0,1'b1,5'd0, 32'h1234,      1'b0,1'b1,5'd1, 1'b0,1'b0,16'd0,5'd3, 32'hDEADBEEF,  1'b0};
    vt[3] = '{1'b0,1'b0,1'b1,5'd7, 32'h7777,      1'b0,1'b1,5'd1, 1'b0,1'b0,16'd0,5'd3, 32'hDEADBEEF,  1'b0};
    vt[4] = '{1'b1,1'b0,1'b1,5'd5, 32'h55,        1'b1,1'b1,5'd1, 1'b0,1'b0,16'd0,5'd5, 32'h55,        1'b1};
    vt[5] = '{1'b1,1'b0,1'b0,5'd0, 32'h0,         1'b1,1'b0,5'd0, 1'b0,1'b0,16'd0,5'd0, 32'h0,         1'b0};
    vt[6] = '{1'b1,1'b0,1'b1,5'd9, 32'h99,        1'b1,1'b1,5'd1, 1'b0,1'b0,16'd0,5'd9, 32'h99,        1'b1};
    vt[7] = '{1'b0,1'b0,1'b1,5'd7, 32'h7,         1'b1,1'b0,5'd0, 1'b0,1'b0,16'd0,5'd0, 32'h0,         1'b0};
    vt[8] = '{1'b1,1'b0,1'b1,5'd2, 32'h22,        1'b0,1'b1,5'd1, 1'b0,1'b0,16'd0,5'd2, 32'h22,        1'b1};
    vt[9] = '{1'b1,1'b1,1'b1,5'd4, 32'h44,        1'b1,1'b0,5'd0, 1'b0,1'b0,16'd0,5'd0, 32'h0,         1'b0};

    do_reset();
    check("rst_vld",   64'(bus.out_valid), 64'd0);
    check("rst_cnt",   64'(count),         64'd0);
    check("rst_full",  64'(full),          64'd0);
    check("rst_entry", 64'(bus.out_entry), 64'd0);

    // Vector table: write capture, r0 filter, enable gating, push/pop, clear
    for (int i = 0; i < 10; i++) begin
      step(vt[i].en, vt[i].clr, vt[i].we, vt[i].rg, vt[i].dat, vt[i].rdy);
      check($sformatf("v%0d_vld", i),  64'(bus.out_valid), 64'(vt[i].e_vld));
      check($sformatf("v%0d_cnt", i),  64'(count),         64'(vt[i].e_cnt));
      check($sformatf("v%0d_full", i), 64'(full),          64'(vt[i].e_full));
      check($sformatf("v%0d_ovf", i),  64'(overflow),      64'(vt[i].e_ovf));
      check($sformatf("v%0d_drop", i), 64'(drop_count),    64'(vt[i].e_drop));
      check($sformatf("v%0d_body", i), 64'(bus.out_entry[36:0]), 64'({vt[i].e_rg, vt[i].e_dat}));
      if (!vt[i].e_vld)
        check($sformatf("v%0d_zero", i), 64'(bus.out_entry), 64'd0);
      if (vt[i].chk_ts)
        check($sformatf("v%0d_ts", i), 64'(bus.out_entry[52:37]), 64'(ts_last));
    end

    // 18 events into a 16-deep FIFO, then drain in order
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 1'b0, 1'b1, 5'(i), 32'(i * 32'h111), 1'b0);
      ts_rec[i-1] = ts_last;
    end
    check("ovf_cnt",  64'(count),      64'd16);
    check("ovf_full", 64'(full),       64'd1);
    check("ovf_flag", 64'(overflow),   64'd1);
    check("ovf_drop", 64'(drop_count), 64'd2);
    for (int i = 1; i <= 16; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      check_head($sformatf("drain%0d", i), 5'(i), 32'(i * 32'h111), ts_rec[i-1]);
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    end
    check("drain_cnt", 64'(count),         64'd0);
    check("drain_vld", 64'(bus.out_valid), 64'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b1, 5'(i), 32'(i), 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd20, 32'hCAFE, 1'b1);
    check("pp_cnt",  64'(count),      64'd16);
    check("pp_full", 64'(full),       64'd1);
    check("pp_ovf",  64'(overflow),   64'd0);
    check("pp_drop", 64'(drop_count), 64'd0);
    check("pp_head", 64'(bus.out_entry[36:32]), 64'd2);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    check("pp_last_cnt", 64'(count),                64'd1);
    check("pp_last_reg", 64'(bus.out_entry[36:32]), 64'd20);
    check("pp_last_dat", 64'(bus.out_entry[31:0]),  64'hCAFE);

    // Clear with 5 entries held, overflow set, and a push on the same edge
    do_reset();
    for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 1'b1, 5'(i), 32'(i), 1'b0);
    for (int i = 0; i < 11; i++)  step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    check("clr_pre_cnt", 64'(count),    64'd5);
    check("clr_pre_ovf", 64'(overflow), 64'd1);
    step(1'b1, 1'b1, 1'b1, 5'd9, 32'h9, 1'b1);
    check("clr_cnt",  64'(count),         64'd0);
    check("clr_vld",  64'(bus.out_valid), 64'd0);
    check("clr_ovf",  64'(overflow),      64'd0);
    check("clr_drop", 64'(drop_count),    64'd0);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b1, 5'(i), 32'(i), 1'b0);
    check("ar_pre_cnt", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cnt",   64'(count),         64'd0);
    check("ar_vld",   64'(bus.out_valid), 64'd0);
    check("ar_entry", 64'(bus.out_entry), 64'd0);
    check("ar_full",  64'(full),          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timestamp wrap and drop-count saturation: edges 0..15 fill, 16..65615 drop
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 5'd1, 32'(i), 1'b0);
    for (int i = 0; i < 65600; i++) step(1'b1, 1'b0, 1'b1, 5'd2, 32'd0, 1'b0);
    check("sat_drop", 64'(drop_count), 64'hFFFF);
    check("sat_ovf",  64'(overflow),   64'd1);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      check_head($sformatf("wrap_head%0d", i), 5'd1, 32'(i), 16'(i));
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 1'b0);
    check_head("wrap_ts", 5'd6, 32'h66, 16'd96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
